// File: rtl/imem_loader.sv
// Boot-time program loader for the single-cycle MIPS core: assembles a byte stream into
// big-endian instruction words, verifies an XOR checksum, then releases the core's PC reset.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [7:0]            i_byte,
  output logic                  o_ready,
  input  logic                  i_reload,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic                  o_cpu_rst_n,
  output logic                  o_done,
  output logic                  o_err
);

  typedef enum logic [2:0] {
    S_CNT_HI = 3'd0,
    S_CNT_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t                state_q;
  logic [15:0]           cnt_q;
  logic [15:0]           word_q;
  logic [7:0]            csum_q;
  logic [1:0]            bidx_q;
  logic [23:0]           shift_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  cpu_rst_n_q;
  logic                  done_q;
  logic                  err_q;

  logic                  accept;
  logic [15:0]           n_hdr;

  // Ready is a pure decode of the state register, so it never depends on inputs.
  assign o_ready = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                   (state_q == S_DATA)   || (state_q == S_CHK);
  assign accept  = i_valid && o_ready;
  assign n_hdr   = {cnt_q[15:8], i_byte};

  assign o_we        = we_q;
  assign o_waddr     = waddr_q;
  assign o_wdata     = wdata_q;
  assign o_cpu_rst_n = cpu_rst_n_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

  // Frame parser FSM with registered write port and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_CNT_HI;
      cnt_q       <= 16'd0;
      word_q      <= 16'd0;
      csum_q      <= 8'd0;
      bidx_q      <= 2'd0;
      shift_q     <= 24'd0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_CNT_HI: begin
          if (accept) begin
            cnt_q[15:8] <= i_byte;
            csum_q      <= csum_step(csum_q, i_byte);
            state_q     <= S_CNT_LO;
          end
        end
        S_CNT_LO: begin
          if (accept) begin
            cnt_q  <= n_hdr;
            csum_q <= csum_step(csum_q, i_byte);
            if (n_hdr == 16'd0) begin
              state_q <= S_CHK;
            end else if ({1'b0, n_hdr} > CAPACITY) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            csum_q <= csum_step(csum_q, i_byte);
            bidx_q <= bidx_q + 2'd1;
            if (bidx_q == 2'd3) begin
              we_q    <= 1'b1;
              waddr_q <= word_q[ADDR_WIDTH-1:0];
              wdata_q <= {shift_q, i_byte};
              word_q  <= word_q + 16'd1;
              if ((word_q + 16'd1) == cnt_q) begin
                state_q <= S_CHK;
              end
            end else begin
              shift_q <= {shift_q[15:0], i_byte};
            end
          end
        end
        S_CHK: begin
          // A correct checksum byte makes the running XOR collapse to zero.
          if (accept) begin
            if (csum_step(csum_q, i_byte) == 8'd0) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              cpu_rst_n_q <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (i_reload) begin
            state_q     <= S_CNT_HI;
            cnt_q       <= 16'd0;
            word_q      <= 16'd0;
            csum_q      <= 8'd0;
            bidx_q      <= 2'd0;
            shift_q     <= 24'd0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
          end
        end
        default: begin
          state_q <= S_CNT_HI;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; expectations come from a frame-level
// model (header length, XOR checksum, word list) computed directly from the byte stream.
module tb_imem_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          i_rst, i_valid, i_reload;
  logic [7:0]    i_byte;
  logic          o_ready, o_we, o_cpu_rst_n, o_done, o_err;
  logic [AW-1:0] o_waddr;
  logic [31:0]   o_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]    frm[$];
  logic [AW-1:0] obs_addr[$];
  logic [31:0]   obs_data[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_byte(i_byte), .o_ready(o_ready),
    .i_reload(i_reload), .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_cpu_rst_n(o_cpu_rst_n), .o_done(o_done), .o_err(o_err)
  );

  // Write monitor: every observed strobe is logged for the frame-level comparison.
  always @(negedge clk) begin
    if (o_we === 1'b1) begin
      obs_addr.push_back(o_waddr);
      obs_data.push_back(o_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] xor_all(input int upto);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < upto; i++) x ^= frm[i];
    return x;
  endfunction

  task automatic make_frame(input int n, input bit corrupt);
    frm.delete();
    frm.push_back(8'(n >> 8));
    frm.push_back(8'(n));
    if (n > (1 << AW)) begin
      for (int i = 0; i < 8; i++) frm.push_back(8'($urandom));
    end else begin
      for (int i = 0; i < 4 * n; i++) frm.push_back(8'($urandom));
      frm.push_back(xor_all(4 * n + 2) ^ {7'd0, corrupt});
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
    check({tag, "_we"}, 32'(o_we), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_err"}, 32'(o_err), 32'd0);
    check({tag, "_cpu_rst_n"}, 32'(o_cpu_rst_n), 32'd0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    @(posedge clk); @(negedge clk);
    i_rst = 1'b0;
    check_idle("rst");
    check("rst_waddr", 32'(o_waddr), 32'd0);
    check("rst_wdata", o_wdata, 32'd0);
  endtask

  task automatic do_reload();
    i_reload = 1'b1;
    @(posedge clk); @(negedge clk);
    i_reload = 1'b0;
    check_idle("reload");
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps. limit<0 runs to the end.
  task automatic run_frame(input int mode, input int limit);
    int n, exp_acc, sent, cyc, nexp;
    bit hdr_err, exp_ok, go;
    logic [31:0] w;
    n = int'({frm[0], frm[1]});
    hdr_err = (n > (1 << AW));
    if (hdr_err) begin
      exp_acc = 2; exp_ok = 1'b0; nexp = 0;
    end else begin
      exp_acc = 4 * n + 3; nexp = n;
      exp_ok = (xor_all(4 * n + 2) == frm[4 * n + 2]);
    end
    obs_addr.delete(); obs_data.delete();
    sent = 0; cyc = 0;
    while (sent < frm.size() && sent != limit && cyc < 20000 && o_ready === 1'b1) begin
      case (mode)
        0:       go = 1'b1;
        1:       go = ((cyc % 2) == 1);
        default: go = ($urandom_range(0, 1) == 1);
      endcase
      i_valid = go; i_byte = frm[sent];
      @(posedge clk); @(negedge clk);
      i_valid = 1'b0; cyc++;
      if (go) begin
        sent++;
        if (!hdr_err && sent >= 6 && sent <= 4 * n + 2 && ((sent - 2) % 4) == 0) begin
          w = {frm[sent-4], frm[sent-3], frm[sent-2], frm[sent-1]};
          check("we_latency", 32'(o_we), 32'd1);
          check("we_addr", 32'(o_waddr), 32'((sent - 2) / 4 - 1));
          check("we_data", o_wdata, w);
          check("core_held", 32'(o_cpu_rst_n), 32'd0);
        end
      end
    end
    if (limit < 0) begin
      check("accepted", 32'(sent), 32'(exp_acc));
      check("done", 32'(o_done), 32'(exp_ok));
      check("err", 32'(o_err), 32'(!exp_ok));
      check("cpu_rst_n", 32'(o_cpu_rst_n), 32'(exp_ok));
      check("ready_low", 32'(o_ready), 32'd0);
      check("nwrites", 32'(obs_addr.size()), 32'(nexp));
      for (int i = 0; i < obs_addr.size() && i < nexp; i++) begin
        check("wr_addr", 32'(obs_addr[i]), 32'(i));
        check("wr_data", obs_data[i],
              {frm[2+4*i], frm[3+4*i], frm[4+4*i], frm[5+4*i]});
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_reload = 1'b0; i_byte = 8'h00;
    @(posedge clk); @(posedge clk); @(negedge clk);
    do_reset();

    // Directed two-word image with a model-computed checksum.
    frm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    frm.push_back(xor_all(10));
    run_frame(0, -1);
    if (obs_data.size() == 2) begin
      check("word0_const", obs_data[0], 32'h20080005);
      check("word1_const", obs_data[1], 32'h01095020);
    end else begin
      check("word_count_const", 32'(obs_data.size()), 32'd2);
    end
    do_reload();

    // Same payload with a literal trailer byte; the model decides pass or fail from XOR.
    frm[10] = 8'h5C;
    run_frame(0, -1);
    do_reload();
    frm[10] = xor_all(10) ^ 8'h01;
    run_frame(0, -1);
    do_reload();

    make_frame(0, 1'b0);
    run_frame(0, -1);
    do_reload();
    make_frame(16'h0101, 1'b0);
    run_frame(0, -1);
    do_reload();
    make_frame(256, 1'b0);
    frm[0] = 8'h01; frm[1] = 8'h00;
    make_frame(2, 1'b0);
    run_frame(1, -1);
    do_reload();

    // Abort after six payload bytes; the loader must restart cleanly.
    make_frame(2, 1'b0);
    run_frame(0, 8);
    obs_addr.delete(); obs_data.delete();
    do_reset();
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("post_rst_we", 32'(o_we), 32'd0);
    end
    check("post_rst_writes", 32'(obs_addr.size()), 32'd0);
    make_frame(2, 1'b0);
    run_frame(0, -1);
    do_reload();

    for (int k = 0; k < 10; k++) begin
      make_frame($urandom_range(1, 6), $urandom_range(0, 3) == 0);
      run_frame($urandom_range(0, 2), -1);
      do_reload();
    end

    make_frame(256, 1'b0);
    run_frame(0, -1);
    if (obs_addr.size() > 0)
      check("last_addr", 32'(obs_addr[obs_addr.size()-1]), 32'hFF);
    do_reload();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
